// File: rtl/issue_select.sv
// Age-ordered issue selector: tracks allocation order of every RS entry in an
// age matrix and maps up to four ready entries, oldest first, onto the ALU ports.

package config_pkg;
  typedef struct packed {
    int RS_DEPTH;
  } cfg_t;

  localparam cfg_t EmptyCfg = '{RS_DEPTH: 16};
endpackage

module issue_select #(
  parameter config_pkg::cfg_t Cfg = config_pkg::EmptyCfg,
  parameter int RS_DEPTH = Cfg.RS_DEPTH,
  parameter int RS_IDX_W = $clog2(Cfg.RS_DEPTH),
  localparam int ISSUE_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic [RS_DEPTH-1:0] alloc_i,
  input  logic [RS_DEPTH-1:0] ready_mask_i,
  input  logic [ISSUE_W-1:0]  alu_ready_i,
  output logic [RS_DEPTH-1:0] issue_grant_o,
  output logic [ISSUE_W-1:0]  issue_valid_o,
  output logic [RS_IDX_W-1:0] sel_idx_0,
  output logic [RS_IDX_W-1:0] sel_idx_1,
  output logic [RS_IDX_W-1:0] sel_idx_2,
  output logic [RS_IDX_W-1:0] sel_idx_3,
  output logic                age_err_o
);

  // older_q[i][j] = 1 : entry i was allocated before entry j
  logic [RS_DEPTH-1:0]                valid_q;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0]  older_q;
  logic                               age_err_q;

  logic [RS_DEPTH-1:0]                valid_d;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0]  older_d;
  logic                               age_err_d;
  logic [RS_DEPTH-1:0]                alloc_eff;

  logic [RS_DEPTH-1:0]                cand;
  logic [RS_DEPTH-1:0]                grant;
  logic [ISSUE_W-1:0]                 port_valid;
  logic [RS_IDX_W-1:0]                sel_arr [ISSUE_W];
  logic                               found;
  logic                               blocked;

  // Serial oldest-first selection chain across the ALU ports
  always_comb begin
    cand       = ready_mask_i & valid_q;
    grant      = '0;
    port_valid = '0;
    found      = 1'b0;
    blocked    = 1'b0;
    for (int k = 0; k < ISSUE_W; k++) begin
      sel_arr[k] = '0;
    end
    for (int k = 0; k < ISSUE_W; k++) begin
      if (alu_ready_i[k]) begin
        found = 1'b0;
        for (int e = 0; e < RS_DEPTH; e++) begin
          blocked = 1'b0;
          for (int j = 0; j < RS_DEPTH; j++) begin
            blocked = blocked | (cand[j] & older_q[j][e]);
          end
          // Lowest index wins only if the matrix were ever inconsistent.
          if (!found && cand[e] && !blocked) begin
            found         = 1'b1;
            port_valid[k] = 1'b1;
            sel_arr[k]    = RS_IDX_W'(e);
            grant[e]      = 1'b1;
          end
        end
        for (int e = 0; e < RS_DEPTH; e++) begin
          if (grant[e]) begin
            cand[e] = 1'b0;
          end
        end
      end
    end
  end

  assign issue_grant_o = grant;
  assign issue_valid_o = port_valid;
  assign sel_idx_0     = sel_arr[0];
  assign sel_idx_1     = sel_arr[1];
  assign sel_idx_2     = sel_arr[2];
  assign sel_idx_3     = sel_arr[3];
  assign age_err_o     = age_err_q;

  // Next-state for tracking; a grant on the same entry drops its allocation
  always_comb begin
    alloc_eff = alloc_i & ~grant;
    valid_d   = (valid_q & ~grant) | alloc_eff;
    older_d   = older_q;
    age_err_d = age_err_q | (|(ready_mask_i & ~valid_q));
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (alloc_eff[i]) begin
        for (int j = 0; j < RS_DEPTH; j++) begin
          if (j != i) begin
            if (valid_q[j] && !alloc_i[j]) begin
              older_d[j][i] = 1'b1;
              older_d[i][j] = 1'b0;
            end else if (alloc_eff[j]) begin
              // Same-cycle allocations: lower index counts as older.
              older_d[i][j] = (i < j);
            end
          end
        end
      end
    end
    if (flush_i) begin
      valid_d = '0;
      older_d = '0;
    end
  end

  // State registers; the error flag survives flush and clears only on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      older_q   <= '0;
      age_err_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      older_q   <= older_d;
      age_err_q <= age_err_d;
    end
  end

endmodule

// File: tb/tb_issue_select.sv
// Bench for issue_select: directed age-ordering scenarios plus randomized
// traffic, compared every cycle against a sequence-number age model.

module tb_issue_select;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush_i = 1'b0;
  logic [D-1:0] alloc_i = '0;
  logic [D-1:0] ready_mask_i = '0;
  logic [3:0]   alu_ready_i = '0;
  logic [D-1:0] issue_grant_o;
  logic [3:0]   issue_valid_o;
  logic [3:0]   sel_idx_0, sel_idx_1, sel_idx_2, sel_idx_3;
  logic         age_err_o;

  int checks = 0;
  int failures = 0;

  issue_select dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .alloc_i      (alloc_i),
    .ready_mask_i (ready_mask_i),
    .alu_ready_i  (alu_ready_i),
    .issue_grant_o(issue_grant_o),
    .issue_valid_o(issue_valid_o),
    .sel_idx_0    (sel_idx_0),
    .sel_idx_1    (sel_idx_1),
    .sel_idx_2    (sel_idx_2),
    .sel_idx_3    (sel_idx_3),
    .age_err_o    (age_err_o)
  );

  always #5 clk = ~clk;

  // Model: an entry's age is the global allocation sequence number it received.
  logic [D-1:0] m_valid;
  int unsigned  m_seq [D];
  int unsigned  seq_cnt;
  logic         m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_sel(input logic [D-1:0] rdy, input logic [3:0] alu,
                           output logic [D-1:0] g, output logic [3:0] v,
                           output logic [3:0][3:0] s);
    logic [D-1:0] c;
    int best;
    c = rdy & m_valid;
    g = '0;
    v = '0;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      if (alu[k]) begin
        best = -1;
        for (int e = 0; e < D; e++) begin
          if (c[e] && (best < 0 || m_seq[e] < m_seq[best])) best = e;
        end
        if (best >= 0) begin
          v[k]    = 1'b1;
          s[k]    = 4'(best);
          g[best] = 1'b1;
          c[best] = 1'b0;
        end
      end
    end
  endtask

  // Model state update at each edge
  always @(posedge clk or negedge rst_n) begin
    logic [D-1:0]     g, nv;
    logic [3:0]       v;
    logic [3:0][3:0]  s;
    int unsigned      n;
    if (!rst_n) begin
      m_valid <= '0;
      m_err   <= 1'b0;
      seq_cnt <= 0;
    end else begin
      model_sel(ready_mask_i, alu_ready_i, g, v, s);
      if (|(ready_mask_i & ~m_valid)) m_err <= 1'b1;
      n  = 0;
      nv = m_valid & ~g;
      if (!flush_i) begin
        for (int i = 0; i < D; i++) begin
          if (alloc_i[i] && !g[i]) begin
            nv[i]    = 1'b1;
            m_seq[i] <= seq_cnt + n;
            n++;
          end
        end
      end else begin
        nv = '0;
      end
      m_valid <= nv;
      seq_cnt <= seq_cnt + n;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic [D-1:0]    eg;
    logic [3:0]      ev;
    logic [3:0][3:0] es;
    if (rst_n) begin
      model_sel(ready_mask_i, alu_ready_i, eg, ev, es);
      check("grant", 32'(issue_grant_o), 32'(eg));
      check("valid", 32'(issue_valid_o), 32'(ev));
      check("sel0", 32'(sel_idx_0), 32'(es[0]));
      check("sel1", 32'(sel_idx_1), 32'(es[1]));
      check("sel2", 32'(sel_idx_2), 32'(es[2]));
      check("sel3", 32'(sel_idx_3), 32'(es[3]));
      check("age_err", 32'(age_err_o), 32'(m_err));
    end
  end

  task automatic drive(input logic [D-1:0] a, input logic [D-1:0] r, input logic [3:0] al, input logic f);
    alloc_i      = a;
    ready_mask_i = r;
    alu_ready_i  = al;
    flush_i      = f;
  endtask

  task automatic step(input logic [D-1:0] a, input logic [D-1:0] r, input logic [3:0] al, input logic f);
    drive(a, r, al, f);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive('0, '0, 4'h0, 1'b0);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [D-1:0] a, r;
    do_reset();

    // 1: age ordering 5, 2, 9
    step(16'h0020, '0, 4'hF, 1'b0);
    step(16'h0004, '0, 4'hF, 1'b0);
    step(16'h0200, '0, 4'hF, 1'b0);
    drive('0, 16'h0224, 4'hF, 1'b0);
    @(negedge clk);
    check("t1_sel0", 32'(sel_idx_0), 5);
    check("t1_sel1", 32'(sel_idx_1), 2);
    check("t1_sel2", 32'(sel_idx_2), 9);
    check("t1_valid", 32'(issue_valid_o), 32'h7);
    check("t1_grant", 32'(issue_grant_o), 32'h0224);
    @(posedge clk); #1;

    // 2: same-cycle tie-break, entries 3 and 1
    step(16'h000A, '0, 4'hF, 1'b0);
    drive('0, 16'h000A, 4'hF, 1'b0);
    @(negedge clk);
    check("t2_sel0", 32'(sel_idx_0), 1);
    check("t2_sel1", 32'(sel_idx_1), 3);
    check("t2_valid", 32'(issue_valid_o), 32'h3);
    @(posedge clk); #1;

    // 3: back-pressure, ages 6 < 0 < 11
    step(16'h0040, '0, 4'hF, 1'b0);
    step(16'h0001, '0, 4'hF, 1'b0);
    step(16'h0800, '0, 4'hF, 1'b0);
    drive('0, 16'h0841, 4'b1010, 1'b0);
    @(negedge clk);
    check("t3_sel1", 32'(sel_idx_1), 6);
    check("t3_sel3", 32'(sel_idx_3), 0);
    check("t3_valid", 32'(issue_valid_o), 32'hA);
    check("t3_grant", 32'(issue_grant_o), 32'h0041);
    @(posedge clk); #1;
    drive('0, 16'h0800, 4'hF, 1'b0);
    @(negedge clk);
    check("t3b_sel0", 32'(sel_idx_0), 11);
    check("t3b_valid", 32'(issue_valid_o), 32'h1);
    @(posedge clk); #1;

    // 4: oversubscription, entries 10..15 in age order
    for (int i = 10; i < 16; i++) begin
      a = '0;
      a[i] = 1'b1;
      step(a, '0, 4'hF, 1'b0);
    end
    drive('0, 16'hFC00, 4'hF, 1'b0);
    @(negedge clk);
    check("t4_grant", 32'(issue_grant_o), 32'h3C00);
    check("t4_sel0", 32'(sel_idx_0), 10);
    check("t4_sel3", 32'(sel_idx_3), 13);
    @(posedge clk); #1;
    drive('0, 16'hC000, 4'hF, 1'b0);
    @(negedge clk);
    check("t4b_sel0", 32'(sel_idx_0), 14);
    check("t4b_sel1", 32'(sel_idx_1), 15);
    check("t4b_valid", 32'(issue_valid_o), 32'h3);
    @(posedge clk); #1;

    // 5a: grant/alloc collision on entry 4
    step(16'h0010, '0, 4'hF, 1'b0);
    drive(16'h0010, 16'h0010, 4'hF, 1'b0);
    @(negedge clk);
    check("t5_grant", 32'(issue_grant_o), 32'h0010);
    @(posedge clk); #1;
    drive('0, 16'h0010, 4'hF, 1'b0);
    @(negedge clk);
    check("t5_dropped", 32'(issue_grant_o), 0);
    @(posedge clk); #1;
    drive('0, '0, 4'hF, 1'b0);
    @(negedge clk);
    check("t5_err", 32'(age_err_o), 1);
    @(posedge clk); #1;

    // 5b: flush clears tracking
    do_reset();
    step(16'h000E, '0, 4'hF, 1'b0);
    step('0, '0, 4'hF, 1'b1);
    step(16'h0080, '0, 4'hF, 1'b0);
    drive('0, 16'h0082, 4'hF, 1'b0);
    @(negedge clk);
    check("t5f_sel0", 32'(sel_idx_0), 7);
    check("t5f_valid", 32'(issue_valid_o), 32'h1);
    check("t5f_grant", 32'(issue_grant_o), 32'h0080);
    @(posedge clk); #1;

    // 6: sticky error flag
    do_reset();
    drive('0, 16'h0080, 4'hF, 1'b0);
    @(negedge clk);
    check("t6_err_pre", 32'(age_err_o), 0);
    check("t6_grant", 32'(issue_grant_o), 0);
    @(posedge clk); #1;
    drive('0, '0, 4'hF, 1'b1);
    @(negedge clk);
    check("t6_err_set", 32'(age_err_o), 1);
    @(posedge clk); #1;
    drive('0, '0, 4'hF, 1'b0);
    @(negedge clk);
    check("t6_err_flush", 32'(age_err_o), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_err_rst", 32'(age_err_o), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic with an asynchronous reset in the middle
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        drive('0, '0, 4'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rnd_rst_grant", 32'(issue_grant_o), 0);
        check("rnd_rst_err", 32'(age_err_o), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      a = (~m_valid) & D'($urandom) & D'($urandom);
      r = m_valid & D'($urandom);
      if ($urandom_range(0, 199) == 0) r[$urandom_range(0, D-1)] = 1'b1;
      step(a, r, 4'($urandom), ($urandom_range(0, 63) == 0));
    end

    drive('0, '0, 4'h0, 1'b0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/issue_select.md
# issue_select

Age-ordered issue selector sitting directly downstream of the reservation station in the backend issue stage. Tracks allocation order of every RS entry in an age matrix. Each cycle it picks up to four ready entries, oldest first, and maps them onto the four ALU ports. It drives the RS read indices (`sel_idx_0..3`) and the per-entry `issue_grant` that frees the slot at the next edge.

## Interface
Parameters:
- `Cfg` — default `config_pkg::EmptyCfg`; source of `RS_DEPTH`.
- `RS_DEPTH` — default `Cfg.RS_DEPTH`; number of RS entries.
- `RS_IDX_W` — default `$clog2(Cfg.RS_DEPTH)`; entry index width.
- `ISSUE_W` — fixed at 4; number of ALU ports.

Ports:
- `clk`, in, 1: clock; all state updates on posedge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `flush_i`, in, 1: pipeline flush; clears all tracking state.
- `alloc_i`, in, RS_DEPTH: per-entry allocation strobe; same vector the RS receives as `entry_wen`.
- `ready_mask_i`, in, RS_DEPTH: RS entries busy with both operands ready.
- `alu_ready_i`, in, 4: ALU k can accept an op this cycle.
- `issue_grant_o`, out, RS_DEPTH: entries issued this cycle; feeds RS `issue_grant`.
- `issue_valid_o`, out, 4: port k carries an op this cycle.
- `sel_idx_0..sel_idx_3`, out, RS_IDX_W each: RS entry read by ALU port k.
- `age_err_o`, out, 1: sticky; set when `ready_mask_i` flags an entry that `issue_select` does not track.

## Operation
State:
- `valid[RS_DEPTH]`: entry tracked.
- `older[i][j]`: 1 means entry i was allocated before entry j. Meaningful only when both are valid.

Allocation, when `alloc_i[i]` is set and `issue_grant_o[i]` is clear:
- Set `valid[i]`.
- For every j with `valid[j]` and `!alloc_i[j]`: `older[j][i]=1`, `older[i][j]=0`.
- Same-cycle multiple allocations: the lower index is older.

Grant and allocation on the same entry in the same cycle: grant wins and the allocation is dropped. This mirrors RS priority.

Grant clears `valid[i]`. Row and column bits are don't-care afterwards.

Candidate set: `C0 = ready_mask_i & valid`.

Selection is a serial chain over ports k = 0..3:
- Skip port k if `!alu_ready_i[k]`.
- Otherwise choose the oldest entry e in the current C: the entry for which no j in C has `older[j][e]`.
- Set `issue_valid_o[k]=1`, `sel_idx_k=e`, `issue_grant_o[e]=1`, then remove e from C.
- If C is empty, the port is idle: valid=0, `sel_idx_k=0`.

Result: the oldest ready op goes to the lowest-index ALU that is ready, the next oldest to the next ready ALU, and so on. No entry is ever granted on two ports.

Flush: `valid` and `older` are cleared, and `alloc_i` is ignored in the flush cycle. `age_err_o` is not cleared by flush. Combinational outputs are still computed from pre-flush state; the RS flush overrides them.

`age_err_o` is set when `|(ready_mask_i & ~valid)`. It clears only on reset.

## Timing
- Selection is zero-latency: `issue_grant_o`, `issue_valid_o` and `sel_idx_*` depend combinationally on `ready_mask_i`, `alu_ready_i` and registered state. The RS reads operands through `sel_idx_*` in the same cycle.
- An entry allocated at edge t can be granted no earlier than cycle t+1, because RS `ready_mask` is registered.
- A granted entry leaves C at the next edge. No double issue occurs, since the RS drops `busy` at that same edge.
- Reset values: `valid=0`, `older=0`, `age_err_o=0`. With no ready entries, all outputs are 0.
- Reset asserted mid-operation clears state immediately (asynchronous). The first allocation after reset is treated as oldest.
- Full RS: all RS_DEPTH entries valid. Ordering stays total; no wrap-around, because age is relative.

## Test plan
1. Age ordering across ports: reset, allocate entry 5, then entry 2, then entry 9 in successive cycles; all ready, all ALUs ready. Required: port0 gets sel=5, port1 sel=2, port2 sel=9; `issue_grant_o` has bits {2,5,9} set; `issue_valid_o=4'b0111`.
2. Same-cycle tie-break: allocate entries 3 and 1 together; both ready. Required: port0 sel=1, port1 sel=3.
3. ALU back-pressure: three ready entries with ages A<B<C and `alu_ready_i=4'b1010`. Required: port1 gets A, port3 gets B, ports 0/2 are invalid, and C stays valid and is issued in the next cycle on port0.
4. Oversubscription: 6 ready entries (ages 0..5), all ALUs ready. Required: the four oldest are granted this cycle; the remaining two are granted next cycle on ports 0 and 1, in age order.
5. Grant/allocate collision and flush: allocate entry 4 in the same cycle entry 4 is granted. Required: entry 4 is not valid afterwards. Then allocate 3 entries, assert `flush_i`, and drive ready_mask=0. Required: all `valid=0`; a subsequent single allocation issues alone on port0.
6. Error flag: with tracking empty, drive `ready_mask_i[7]=1`. Required: `age_err_o` rises at the next edge and stays high through a flush; only `rst_n` low clears it.
